spiflash_reader: RTL and testbench

- SPI flash read initiator. It issues standard 0x03 READ transactions and returns one 32-bit word per request.
- It is the opposite end of the spiflash responder, which serves SPI reads from bram on the FPGA platform.
- It gives FPGA-side user logic (e.g. an FIR coefficient loader) direct access to the flash image without going through the management core.
- SPI mode 0: clock idles low, MOSI launched while clock is low, MISO sampled on the rising edge.

---
 rtl/spiflash_reader.sv | 122 ++++++++++++
 tb/tb_spiflash_reader.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spiflash_reader.sv
// SPI flash read initiator: issues mode-0 0x03 READ transactions and returns one
// little-endian 32-bit word per request.
module spiflash_reader #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned CSB_HIGH = 2
) (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_addr,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        csb,
  output logic        spiclk,
  output logic        io0,
  input  logic        io1
);

  typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

  localparam logic [7:0] DivLast = 8'(CLK_DIV - 1);
  localparam logic [7:0] GapLast = 8'(CSB_HIGH - 1);

  state_e      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic        high_q, high_d;
  logic [5:0]  bit_q, bit_d;
  logic [7:0]  gap_q, gap_d;
  logic [31:0] tx_q, tx_d;
  logic [31:0] rx_q, rx_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    high_d      = high_q;
    bit_d       = bit_q;
    gap_d       = gap_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    req_ready   = 1'b0;
    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          tx_d    = {8'h03, req_addr[23:2], 2'b00};
          rx_d    = '0;
          bit_d   = '0;
          div_d   = '0;
          high_d  = 1'b0;
          state_d = StShift;
        end
      end
      StShift: begin
        if (div_q == DivLast) begin
          div_d  = '0;
          high_d = ~high_q;
          if (!high_q) begin
            // Rising spiclk edge: data bits 32..63 land MSB-first in byte bit_q[4:3].
            if (bit_q[5]) begin
              rx_d[{bit_q[4:3], ~bit_q[2:0]}] = io1;
            end
          end else if (bit_q == 6'd63) begin
            state_d     = StGap;
            gap_d       = '0;
            rsp_valid_d = 1'b1;
            rsp_data_d  = rx_q;
          end else begin
            bit_d = bit_q + 6'd1;
            tx_d  = {tx_q[30:0], 1'b0};
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      StGap: begin
        if (gap_q == GapLast) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      default: state_d = StGap;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q     <= StGap;
      div_q       <= '0;
      high_q      <= 1'b0;
      bit_q       <= '0;
      gap_q       <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      high_q      <= high_d;
      bit_q       <= bit_d;
      gap_q       <= gap_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Pins decode straight from state so reset forces them idle without waiting for a clock.
  assign csb       = (state_q != StShift);
  assign spiclk    = (state_q == StShift) && high_q;
  assign io0       = (state_q == StShift) && !bit_q[5] && tx_q[31];
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_spiflash_reader.sv
// Bench for spiflash_reader: two instances (CLK_DIV=2 and CLK_DIV=1) against a
// behavioural flash responder and a word-level reference model.
module tb_spiflash_reader;

  localparam int CSB_HIGH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid [2];
  logic        req_ready [2];
  logic [23:0] req_addr  [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_data  [2];
  logic        csb       [2];
  logic        spiclk    [2];
  logic        io0       [2];
  logic        io1       [2] = '{1'b0, 1'b0};

  always #5 clk = ~clk;

  spiflash_reader #(.CLK_DIV(2), .CSB_HIGH(CSB_HIGH)) u_dut0 (
    .ap_clk(clk), .ap_rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
    .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]),
    .csb(csb[0]), .spiclk(spiclk[0]), .io0(io0[0]), .io1(io1[0])
  );

  spiflash_reader #(.CLK_DIV(1), .CSB_HIGH(CSB_HIGH)) u_dut1 (
    .ap_clk(clk), .ap_rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
    .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]),
    .csb(csb[1]), .spiclk(spiclk[1]), .io0(io0[1]), .io1(io1[1])
  );

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Flash image: explicit bytes where the scenarios need them, a hash elsewhere.
  bit [7:0] mem_ovr [int];

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    if (mem_ovr.exists(int'(a))) return mem_ovr[int'(a)];
    return (a[7:0] * 8'd37) ^ a[15:8] ^ a[23:16] ^ 8'h5a;
  endfunction

  function automatic logic [31:0] ref_word(input logic [23:0] addr);
    logic [23:0] b;
    b = {addr[23:2], 2'b00};
    return {mem_byte(b + 24'd3), mem_byte(b + 24'd2), mem_byte(b + 24'd1), mem_byte(b)};
  endfunction

  function automatic int div_of(input int g);
    return (g == 0) ? 2 : 1;
  endfunction

  typedef struct {
    int          acc;
    logic [31:0] exp;
    logic [31:0] cmd;
  } acc_t;

  acc_t        pend [2][$];
  acc_t        e;
  int          cyc = 0;
  int          cnt [2], last_rise [2], csb_fall [2], bad [2], busy_bad [2];
  int          high_run [2], last_gap [2], acc_last [2], last_lat [2], n_rsp [2];
  logic [31:0] mosi [2], last_rsp [2];
  logic        prev_csb [2] = '{1'b1, 1'b1};
  logic        prev_clk [2] = '{1'b0, 1'b0};
  bit          glitch_en [2];
  int          j;
  logic [7:0]  b;

  // Responder plus protocol monitor, evaluated mid-cycle once DUT outputs have settled.
  always @(posedge clk) begin
    cyc++;
    #4;
    for (int g = 0; g < 2; g++) begin
      if (rst) begin
        pend[g].delete();
        cnt[g] = 0;
      end else begin
        if (req_valid[g] && req_ready[g]) begin
          e.acc = cyc;
          e.exp = ref_word(req_addr[g]);
          e.cmd = {8'h03, req_addr[g][23:2], 2'b00};
          pend[g].push_back(e);
          acc_last[g] = cyc;
        end
        if (!csb[g] && req_ready[g]) busy_bad[g]++;
        if (prev_csb[g] && !csb[g]) begin
          csb_fall[g] = cyc;
          last_gap[g] = high_run[g];
          bad[g]      = 0;
          busy_bad[g] = 0;
          cnt[g]      = 0;
          mosi[g]     = '0;
        end
        if (spiclk[g] && !prev_clk[g]) begin
          if (cnt[g] == 0) begin
            if (cyc - csb_fall[g] != div_of(g)) bad[g]++;
          end else if (cyc - last_rise[g] != 2 * div_of(g)) begin
            bad[g]++;
          end
          if (cnt[g] < 32) mosi[g] = {mosi[g][30:0], io0[g]};
          else if (io0[g]) bad[g]++;
          cnt[g]++;
          last_rise[g] = cyc;
          // Bit 40's high half: a flip here must never reach the captured word.
          if (glitch_en[g] && cnt[g] == 41) io1[g] = ~io1[g];
        end
        if (!spiclk[g] && prev_clk[g]) begin
          if (cyc - last_rise[g] != div_of(g)) bad[g]++;
          if (cnt[g] >= 32 && cnt[g] < 64) begin
            j      = cnt[g] - 32;
            b      = mem_byte(mosi[g][23:0] + 24'(j / 8));
            io1[g] = b[7 - (j % 8)];
          end else begin
            io1[g] = 1'($urandom);
          end
        end
        if (!prev_csb[g] && csb[g]) begin
          check_eq($sformatf("u%0d.rises", g), cnt[g], 64);
          check_eq($sformatf("u%0d.spi_timing", g), bad[g], 0);
          check_eq($sformatf("u%0d.ready_busy", g), busy_bad[g], 0);
          check_eq($sformatf("u%0d.pend_at_csb", g), pend[g].size() != 0, 1);
          if (pend[g].size() != 0) check_eq($sformatf("u%0d.mosi", g), mosi[g], pend[g][0].cmd);
        end
        if (rsp_valid[g]) begin
          check_eq($sformatf("u%0d.rsp_pending", g), pend[g].size() != 0, 1);
          check_eq($sformatf("u%0d.ready_gap", g), req_ready[g], 0);
          if (pend[g].size() != 0) begin
            e = pend[g].pop_front();
            check_eq($sformatf("u%0d.rsp_data", g), rsp_data[g], e.exp);
            check_eq($sformatf("u%0d.latency", g), cyc - e.acc, 1 + 128 * div_of(g));
            last_lat[g] = cyc - e.acc;
          end
          last_rsp[g] = rsp_data[g];
          n_rsp[g]++;
        end
        if (csb[g]) high_run[g]++;
        else high_run[g] = 0;
      end
      prev_csb[g] = csb[g];
      prev_clk[g] = spiclk[g];
    end
  end

  task automatic send_req(input int g, input logic [23:0] addr, input bit hold);
    int   waited = 0;
    bit   ok = 0;
    logic rdy;
    @(posedge clk);
    #1;
    req_valid[g] = 1'b1;
    req_addr[g]  = addr;
    while (!ok && waited < 2000) begin
      rdy = req_ready[g];
      @(posedge clk);
      #1;
      if (rdy) ok = 1;
      waited++;
    end
    check_eq($sformatf("u%0d.accept", g), ok, 1);
    if (!hold) begin
      req_valid[g] = 1'b0;
      req_addr[g]  = 24'($urandom);
    end
  endtask

  task automatic wait_idle(input int g);
    int waited = 0;
    while (pend[g].size() != 0 && waited < 2000) begin
      @(posedge clk);
      waited++;
    end
    check_eq($sformatf("u%0d.rsp_timeout", g), pend[g].size(), 0);
    repeat (2) @(posedge clk);
  endtask

  task automatic release_and_check_ready();
    @(posedge clk);
    #6 rst = 1'b0;
    @(posedge clk);
    #4 check_eq("ready_gap_after_rst", req_ready[0], 0);
    @(posedge clk);
    #4 check_eq("ready_after_rst", req_ready[0], 1);
  endtask

  initial begin
    int a0, a1, saved, k;
    req_valid = '{1'b0, 1'b0};
    req_addr  = '{24'd0, 24'd0};
    mem_ovr[32'h100] = 8'h13; mem_ovr[32'h101] = 8'h05;
    mem_ovr[32'h102] = 8'h00; mem_ovr[32'h103] = 8'h00;
    mem_ovr[32'hFFFFFC] = 8'hDE; mem_ovr[32'hFFFFFD] = 8'hAD;
    mem_ovr[32'hFFFFFE] = 8'hBE; mem_ovr[32'hFFFFFF] = 8'hEF;

    #1 rst = 1'b1;
    #2;
    for (int g = 0; g < 2; g++) begin
      check_eq($sformatf("u%0d.rst_csb", g), csb[g], 1);
      check_eq($sformatf("u%0d.rst_spiclk", g), spiclk[g], 0);
      check_eq($sformatf("u%0d.rst_io0", g), io0[g], 0);
      check_eq($sformatf("u%0d.rst_ready", g), req_ready[g], 0);
      check_eq($sformatf("u%0d.rst_rsp_valid", g), rsp_valid[g], 0);
      check_eq($sformatf("u%0d.rst_rsp_data", g), rsp_data[g], 0);
    end
    release_and_check_ready();

    // Known image word, with an io1 glitch in bit 40's high half.
    glitch_en[0] = 1'b1;
    send_req(0, 24'h000100, 1'b0);
    wait_idle(0);
    glitch_en[0] = 1'b0;
    check_eq("tp_word_0x100", last_rsp[0], 32'h0000_0513);
    check_eq("tp_latency_div2", last_lat[0], 257);

    // Low address bits are dropped.
    send_req(0, 24'h000103, 1'b0);
    wait_idle(0);
    check_eq("tp_word_0x103", last_rsp[0], 32'h0000_0513);

    // req_valid held across two back-to-back requests.
    saved = n_rsp[0];
    send_req(0, 24'h000000, 1'b1);
    a0 = acc_last[0];
    send_req(0, 24'h000004, 1'b0);
    a1 = acc_last[0];
    wait_idle(0);
    check_eq("b2b_spacing", a1 - a0, 1 + 128 * 2 + CSB_HIGH);
    // csb stays high for the GAP cycles plus the IDLE cycle that accepts the next request.
    check_eq("b2b_csb_high", last_gap[0], CSB_HIGH + 1);
    check_eq("b2b_rsp_count", n_rsp[0] - saved, 2);
    check_eq("b2b_last_word", last_rsp[0], ref_word(24'h000004));

    // CLK_DIV=1 at the top of the address space.
    glitch_en[1] = 1'b1;
    send_req(1, 24'hFFFFFC, 1'b0);
    wait_idle(1);
    glitch_en[1] = 1'b0;
    check_eq("tp_word_top", last_rsp[1], 32'hEFBE_ADDE);
    check_eq("tp_latency_div1", last_lat[1], 129);

    // Reset after 20 data bits.
    send_req(0, 24'($urandom), 1'b0);
    k = 0;
    while (cnt[0] < 52 && k < 2000) begin
      @(posedge clk);
      #5;
      k++;
    end
    check_eq("abort_reached_bit52", cnt[0] >= 52, 1);
    #1 rst = 1'b1;
    #1;
    check_eq("abort_csb", csb[0], 1);
    check_eq("abort_spiclk", spiclk[0], 0);
    saved = n_rsp[0];
    @(posedge clk);
    release_and_check_ready();
    repeat (300) @(posedge clk);
    check_eq("abort_no_rsp", n_rsp[0], saved);
    send_req(0, 24'h000100, 1'b0);
    wait_idle(0);
    check_eq("after_abort_word", last_rsp[0], 32'h0000_0513);

    // Random requests on both instances.
    for (int i = 0; i < 8; i++) begin
      int g;
      g = int'($urandom_range(0, 1));
      glitch_en[g] = 1'($urandom);
      send_req(g, 24'($urandom), 1'b0);
      repeat ($urandom_range(0, 5)) @(posedge clk);
      wait_idle(g);
      glitch_en[g] = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
